pcpi_rr_arbiter: RTL and testbench
==================================

// Module: pcpi_rr_arbiter
// PURPOSE
//  Shares one PCPI coprocessor (fused matrix-multiply unit) among NUM_REQ requesters.
//  Round-robin arbitration, one instruction in flight. Issues the winning instruction on
//  the PCPI bus, enforces a no-response timeout and routes rd/wr back to the owner.
//  Sits between the nibble-deserialising front-ends and the PCPI coprocessor.
// PARAMETERS
//  NUM_REQ   4   number of requesters (>=2)
//  TIMEOUT   16  max BUSY cycles with pcpi_wait=0 and pcpi_ready=0 before abort (>=2)
// PORTS
//  clk           in   1           clock
//  rst_n         in   1           reset, synchronous, active-low
//  req_valid     in   NUM_REQ     per-requester request; held with req_insn until req_accept
//  req_insn      in   32*NUM_REQ  instruction of requester i at [32*i+31:32*i]
//  req_accept    out  NUM_REQ     one-hot, 1-cycle pulse: request taken
//  resp_valid    out  NUM_REQ     one-hot, 1-cycle pulse: response for that requester
//  resp_rd       out  32          result; valid only with resp_valid
//  resp_wr       out  1           coprocessor write-back flag; valid with resp_valid
//  resp_timeout  out  1           1 = aborted by timeout; valid with resp_valid
//  busy          out  1           1 while an instruction is owned (BUSY or RESP)
//  pcpi_valid    out  1           PCPI request to coprocessor
//  pcpi_insn     out  32          PCPI instruction (registered, stable while pcpi_valid)
//  pcpi_ready    in   1           coprocessor done
//  pcpi_wr       in   1           coprocessor result write enable
//  pcpi_wait     in   1           coprocessor acknowledges, still working
//  pcpi_rd       in   32          coprocessor result
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, timeout count 0, RR pointer last=NUM_REQ-1 (req 0 first).
//    Reset mid-operation aborts silently: no resp_valid for the in-flight owner.
//  - States: IDLE -> BUSY -> RESP -> IDLE. All outputs registered.
//  - IDLE: if any req_valid, winner = first set bit scanning last+1, last+2, ... (mod NUM_REQ).
//    Edge: latch req_insn[winner] to pcpi_insn, owner<=winner, pcpi_valid<=1,
//    req_accept[winner]<=1 (one cycle), count<=0, -> BUSY. No request: stay, outputs 0.
//  - BUSY: pcpi_valid held 1, pcpi_insn stable. Priority per edge:
//    1) pcpi_ready=1: resp_rd<=pcpi_rd, resp_wr<=pcpi_wr, resp_timeout<=0, pcpi_valid<=0, -> RESP.
//    2) pcpi_wait=1: count<=0, stay.
//    3) count==TIMEOUT-1: resp_rd<=0, resp_wr<=0, resp_timeout<=1, pcpi_valid<=0, -> RESP.
//    4) else count<=count+1.
//    Ready on the same edge as timeout threshold: ready wins (no timeout).
//  - RESP: resp_valid[owner]=1 for exactly this cycle; last<=owner; -> IDLE. Requests are not
//    sampled in RESP (gives coprocessor one cycle with pcpi_valid=0 to drop pcpi_ready).
//  - Latency: req seen at edge k -> req_accept and pcpi_valid high cycle k..; pcpi_ready at edge m
//    -> resp_valid cycle m..m+1; next grant earliest edge m+2.
//  - req_valid/req_insn changes before req_accept are legal; value sampled at grant edge is used.
//    Requester i may re-request during its own BUSY; it is arbitrated normally at next IDLE.
//  - pcpi_ready/pcpi_wait/pcpi_rd ignored outside BUSY. count width $clog2(TIMEOUT).
//  - Invariants: req_accept, resp_valid each at most one bit set; pcpi_valid=1 iff state BUSY.
// TESTING
//  1 req_valid[0], insn 0x0000_200B; ready+wr=1+rd=0x1234_5678 on 5th BUSY cycle ->
//    req_accept=0001 one cycle, pcpi_valid 5 cycles, resp_valid=0001 rd=0x1234_5678 wr=1 to=0.
//  2 All four req_valid held from reset, coproc ready after 2 cycles -> accept order 0,1,2,3,0;
//    then only req 0 and req 3 pending after grant to 1 -> order 3 then 0.
//  3 Coproc silent (wait=0, ready=0) -> pcpi_valid high exactly 16 cycles, resp_timeout=1,
//    resp_rd=0, resp_wr=0; next request still granted normally.
//  4 pcpi_wait=1 for 100 cycles then ready with rd=0xDEAD_BEEF wr=0 -> no timeout,
//    resp_rd=0xDEAD_BEEF resp_wr=0.
//  5 rst_n low during BUSY of req 2 -> next cycle all outputs 0, no resp_valid; after release
//    req 2 and req 0 pending -> req 0 granted first.
//  6 pcpi_ready asserted on the 16th silent BUSY cycle -> resp_timeout=0, rd returned.

Source files
------------

// File: rtl/pcpi_rr_arbiter_if.sv
// Requester-side and PCPI-side signals of the shared-coprocessor arbiter.
// master = arbiter view, slave = view of the requesters/coprocessor environment.
interface pcpi_rr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_insn;
  logic [NUM_REQ-1:0]    req_accept;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_rd;
  logic                  resp_wr;
  logic                  resp_timeout;
  logic                  busy;
  logic                  pcpi_valid;
  logic [31:0]           pcpi_insn;
  logic                  pcpi_ready;
  logic                  pcpi_wr;
  logic                  pcpi_wait;
  logic [31:0]           pcpi_rd;

  modport master (
    input  req_valid, req_insn, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd,
    output req_accept, resp_valid, resp_rd, resp_wr, resp_timeout, busy,
           pcpi_valid, pcpi_insn
  );

  modport slave (
    output req_valid, req_insn, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd,
    input  req_accept, resp_valid, resp_rd, resp_wr, resp_timeout, busy,
           pcpi_valid, pcpi_insn
  );
endinterface

// File: rtl/pcpi_rr_arbiter.sv
// Round-robin sharing of one PCPI coprocessor among NUM_REQ requesters, one
// instruction in flight, with a no-response timeout and routed responses.
module pcpi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst_n,
  pcpi_rr_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);
  localparam logic [IDX_W-1:0]   LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMEOUT - 1);

  logic [1:0]         state_reg;
  logic [IDX_W-1:0]   last_reg;
  logic [IDX_W-1:0]   owner_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [NUM_REQ-1:0] req_accept_reg;
  logic [NUM_REQ-1:0] resp_valid_reg;
  logic [31:0]        resp_rd_reg;
  logic               resp_wr_reg;
  logic               resp_timeout_reg;
  logic               busy_reg;
  logic               pcpi_valid_reg;
  logic [31:0]        pcpi_insn_reg;

  logic [31:0] insn_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_insn
      assign insn_arr[gi] = bus.req_insn[32*gi +: 32];
    end
  endgenerate

  // Scan last+1, last+2, ... so the most recent owner gets lowest priority.
  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  int               scan_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(last_reg) + k) % NUM_REQ;
      if (!grant_found && bus.req_valid[IDX_W'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(scan_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      last_reg         <= LAST_INIT;
      owner_reg        <= '0;
      count_reg        <= '0;
      req_accept_reg   <= '0;
      resp_valid_reg   <= '0;
      resp_rd_reg      <= '0;
      resp_wr_reg      <= 1'b0;
      resp_timeout_reg <= 1'b0;
      busy_reg         <= 1'b0;
      pcpi_valid_reg   <= 1'b0;
      pcpi_insn_reg    <= '0;
    end else begin
      req_accept_reg <= '0;
      resp_valid_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_found) begin
            pcpi_insn_reg  <= insn_arr[grant_idx];
            owner_reg      <= grant_idx;
            pcpi_valid_reg <= 1'b1;
            req_accept_reg <= ONE_HOT0 << grant_idx;
            count_reg      <= '0;
            busy_reg       <= 1'b1;
            state_reg      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Ready beats the timeout when both land on the same edge.
          if (bus.pcpi_ready) begin
            resp_rd_reg      <= bus.pcpi_rd;
            resp_wr_reg      <= bus.pcpi_wr;
            resp_timeout_reg <= 1'b0;
            resp_valid_reg   <= ONE_HOT0 << owner_reg;
            pcpi_valid_reg   <= 1'b0;
            pcpi_insn_reg    <= '0;
            state_reg        <= ST_RESP;
          end else if (bus.pcpi_wait) begin
            count_reg <= '0;
          end else if (count_reg == CNT_LAST) begin
            resp_rd_reg      <= '0;
            resp_wr_reg      <= 1'b0;
            resp_timeout_reg <= 1'b1;
            resp_valid_reg   <= ONE_HOT0 << owner_reg;
            pcpi_valid_reg   <= 1'b0;
            pcpi_insn_reg    <= '0;
            state_reg        <= ST_RESP;
          end else begin
            count_reg <= count_reg + CNT_W'(1);
          end
        end
        ST_RESP: begin
          // Requests are not sampled here, giving the coprocessor a
          // pcpi_valid=0 cycle to drop pcpi_ready.
          last_reg         <= owner_reg;
          busy_reg         <= 1'b0;
          resp_rd_reg      <= '0;
          resp_wr_reg      <= 1'b0;
          resp_timeout_reg <= 1'b0;
          state_reg        <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_accept   = req_accept_reg;
  assign bus.resp_valid   = resp_valid_reg;
  assign bus.resp_rd      = resp_rd_reg;
  assign bus.resp_wr      = resp_wr_reg;
  assign bus.resp_timeout = resp_timeout_reg;
  assign bus.busy         = busy_reg;
  assign bus.pcpi_valid   = pcpi_valid_reg;
  assign bus.pcpi_insn    = pcpi_insn_reg;
endmodule

// File: tb/tb_pcpi_rr_arbiter.sv
// Scoreboard bench for pcpi_rr_arbiter: stimulus queues expected grants,
// responses and pcpi_valid lengths; a negedge monitor pops and compares.
module tb_pcpi_rr_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pcpi_rr_arbiter_if #(.NUM_REQ(N)) bus ();

  pcpi_rr_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {int idx; logic [31:0] insn;} acc_t;
  typedef struct {int idx; logic [31:0] rd; logic wr; logic to;} resp_t;

  acc_t  exp_acc[$];
  resp_t exp_resp[$];
  int    exp_pv[$];   // -1: pcpi_valid burst ended by reset, length not checked

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  bit done = 1'b0;

  int issued [N];
  int acc_cnt [N];
  int cp_ready_cyc = 2;
  int cp_wait_n = 0;
  bit cp_fixed = 1'b0;
  logic [31:0] cp_rd = '0;
  logic cp_wr = 1'b1;

  // Requesters and coprocessor model, driven just after each rising edge.
  initial begin
    int cyc;
    cyc = 0;
    bus.req_valid  = '0;
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = '0;
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (bus.req_accept[i] === 1'b1) acc_cnt[i]++;
        bus.req_valid[i] = (issued[i] > acc_cnt[i]);
      end
      if (bus.pcpi_valid === 1'b1) begin
        cyc++;
        bus.pcpi_ready = (cp_ready_cyc != 0) && (cyc == cp_ready_cyc);
        bus.pcpi_wait  = (cyc <= cp_wait_n);
        bus.pcpi_wr    = cp_wr;
        bus.pcpi_rd    = cp_fixed ? cp_rd : ~bus.pcpi_insn;
      end else begin
        cyc = 0;
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wait  = 1'b0;
        bus.pcpi_wr    = 1'b1;
        bus.pcpi_rd    = 32'h5555_AAAA;
      end
    end
  end

  // Monitor: sole owner of checks/errors, prints the summary.
  initial begin
    int pv_run;
    bit rst_low_prev;
    acc_t a;
    resp_t r;
    int p;
    logic [N-1:0] one;
    logic [N-1:0] oh;
    pv_run = 0;
    rst_low_prev = 1'b0;
    one = 1;
    forever begin
      @(negedge clk);
      if (done) begin
        checks++;
        if (stall_cnt != 0 || exp_acc.size() != 0 || exp_resp.size() != 0 || exp_pv.size() != 0) begin
          errors++;
          $display("FAIL leftover: stalls=%0d acc=%0d resp=%0d pv=%0d required all 0",
                   stall_cnt, exp_acc.size(), exp_resp.size(), exp_pv.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      if (!rst_n && rst_low_prev) begin
        checks++;
        if ({bus.req_accept, bus.resp_valid, bus.resp_rd, bus.resp_wr, bus.resp_timeout,
             bus.busy, bus.pcpi_valid, bus.pcpi_insn} !== '0) begin
          errors++;
          $display("FAIL reset_outputs: acc=%b rv=%b rd=%h wr=%b to=%b busy=%b pv=%b insn=%h required all 0",
                   bus.req_accept, bus.resp_valid, bus.resp_rd, bus.resp_wr, bus.resp_timeout,
                   bus.busy, bus.pcpi_valid, bus.pcpi_insn);
        end
      end
      rst_low_prev = !rst_n;

      if (bus.req_accept !== '0 && bus.req_accept !== 'x) begin
        checks++;
        if (exp_acc.size() == 0) begin
          errors++;
          $display("FAIL accept_unexpected: req_accept=%b required none", bus.req_accept);
        end else begin
          a = exp_acc.pop_front();
          oh = one << a.idx;
          if (bus.req_accept !== oh || bus.pcpi_insn !== a.insn || bus.pcpi_valid !== 1'b1) begin
            errors++;
            $display("FAIL accept: req_accept=%b insn=%h pv=%b required %b insn=%h pv=1",
                     bus.req_accept, bus.pcpi_insn, bus.pcpi_valid, oh, a.insn);
          end else begin
            $display("accept req %0d insn %h", a.idx, a.insn);
          end
        end
      end

      if (bus.resp_valid !== '0 && bus.resp_valid !== 'x) begin
        checks++;
        if (exp_resp.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: resp_valid=%b required none", bus.resp_valid);
        end else begin
          r = exp_resp.pop_front();
          oh = one << r.idx;
          if (bus.resp_valid !== oh || bus.resp_rd !== r.rd || bus.resp_wr !== r.wr ||
              bus.resp_timeout !== r.to || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL resp: rv=%b rd=%h wr=%b to=%b busy=%b required rv=%b rd=%h wr=%b to=%b busy=1",
                     bus.resp_valid, bus.resp_rd, bus.resp_wr, bus.resp_timeout, bus.busy,
                     oh, r.rd, r.wr, r.to);
          end else begin
            $display("resp req %0d rd %h wr %b to %b", r.idx, r.rd, r.wr, r.to);
          end
        end
      end

      if (bus.pcpi_valid === 1'b1) begin
        pv_run++;
      end else if (pv_run > 0) begin
        if (exp_pv.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pv_unexpected: pcpi_valid burst of %0d cycles required none", pv_run);
        end else begin
          p = exp_pv.pop_front();
          if (p >= 0) begin
            checks++;
            if (pv_run != p) begin
              errors++;
              $display("FAIL pv_len: pcpi_valid high %0d cycles required %0d", pv_run, p);
            end else begin
              $display("pcpi_valid burst %0d cycles", pv_run);
            end
          end
        end
        pv_run = 0;
      end
    end
  end

  task automatic expect_txn(input int idx, input logic [31:0] insn, input logic [31:0] rd,
                            input logic wr, input logic to, input int pv);
    acc_t a;
    resp_t r;
    a.idx = idx; a.insn = insn;
    r.idx = idx; r.rd = rd; r.wr = wr; r.to = to;
    exp_acc.push_back(a);
    exp_resp.push_back(r);
    exp_pv.push_back(pv);
  endtask

  task automatic drain(input int budget, input bit acc_only);
    int t;
    t = 0;
    while (t < budget && (exp_acc.size() != 0 ||
           (!acc_only && (exp_resp.size() != 0 || exp_pv.size() != 0)))) begin
      @(negedge clk);
      t++;
    end
    if (exp_acc.size() != 0 || (!acc_only && (exp_resp.size() != 0 || exp_pv.size() != 0))) begin
      stall_cnt++;
      $display("FAIL drain_timeout: %0d cycles waited, required queues empty", budget);
    end
  endtask

  function automatic logic [31:0] insn_of(input int i);
    return 32'hA000_100B + 32'(i) * 32'h0001_0000;
  endfunction

  initial begin
    acc_t a;
    rst_n = 1'b0;
    bus.req_insn = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_insn[32*i +: 32] = insn_of(i);
      issued[i] = 1;
    end
    issued[0] = 2;

    // All four held from reset, coprocessor ready on 2nd cycle: 0,1,2,3,0.
    expect_txn(0, insn_of(0), ~insn_of(0), 1'b1, 1'b0, 2);
    expect_txn(1, insn_of(1), ~insn_of(1), 1'b1, 1'b0, 2);
    expect_txn(2, insn_of(2), ~insn_of(2), 1'b1, 1'b0, 2);
    expect_txn(3, insn_of(3), ~insn_of(3), 1'b1, 1'b0, 2);
    expect_txn(0, insn_of(0), ~insn_of(0), 1'b1, 1'b0, 2);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    drain(400, 1'b0);

    // last=0 with 0,1,3 pending: 1 first, then 3, then 0.
    @(posedge clk); #2;
    expect_txn(1, insn_of(1), ~insn_of(1), 1'b1, 1'b0, 2);
    expect_txn(3, insn_of(3), ~insn_of(3), 1'b1, 1'b0, 2);
    expect_txn(0, insn_of(0), ~insn_of(0), 1'b1, 1'b0, 2);
    issued[0]++; issued[1]++; issued[3]++;
    drain(400, 1'b0);

    // Single request, ready on 5th BUSY cycle.
    @(posedge clk); #2;
    cp_ready_cyc = 5; cp_wait_n = 0; cp_fixed = 1'b1; cp_rd = 32'h1234_5678; cp_wr = 1'b1;
    bus.req_insn[31:0] = 32'h0000_200B;
    expect_txn(0, 32'h0000_200B, 32'h1234_5678, 1'b1, 1'b0, 5);
    issued[0]++;
    drain(400, 1'b0);

    // Silent coprocessor: timeout after exactly 16 cycles, rd/wr zeroed.
    @(posedge clk); #2;
    cp_ready_cyc = 0; cp_wait_n = 0; cp_fixed = 1'b1; cp_rd = 32'hFFFF_FFFF; cp_wr = 1'b1;
    bus.req_insn[63:32] = 32'h0200_000B;
    expect_txn(1, 32'h0200_000B, 32'h0000_0000, 1'b0, 1'b1, 16);
    issued[1]++;
    drain(400, 1'b0);

    // Long pcpi_wait keeps clearing the counter; then ready.
    @(posedge clk); #2;
    cp_ready_cyc = 101; cp_wait_n = 100; cp_fixed = 1'b1; cp_rd = 32'hDEAD_BEEF; cp_wr = 1'b0;
    bus.req_insn[95:64] = 32'h0300_000B;
    expect_txn(2, 32'h0300_000B, 32'hDEAD_BEEF, 1'b0, 1'b0, 101);
    issued[2]++;
    drain(400, 1'b0);

    // Ready on the 16th silent cycle wins over the timeout.
    @(posedge clk); #2;
    cp_ready_cyc = 16; cp_wait_n = 0; cp_fixed = 1'b1; cp_rd = 32'h0BAD_F00D; cp_wr = 1'b1;
    bus.req_insn[127:96] = 32'h0400_000B;
    expect_txn(3, 32'h0400_000B, 32'h0BAD_F00D, 1'b1, 1'b0, 16);
    issued[3]++;
    drain(400, 1'b0);

    // Reset during BUSY of req 2: no response; afterwards req 0 before req 2.
    @(posedge clk); #2;
    cp_ready_cyc = 0; cp_wait_n = 0; cp_fixed = 1'b0; cp_wr = 1'b1;
    for (int i = 0; i < N; i++) bus.req_insn[32*i +: 32] = insn_of(i);
    a.idx = 2; a.insn = insn_of(2);
    exp_acc.push_back(a);
    exp_pv.push_back(-1);
    issued[2]++;
    drain(100, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    cp_ready_cyc = 3;
    issued[0]++; issued[2]++;
    expect_txn(0, insn_of(0), ~insn_of(0), 1'b1, 1'b0, 3);
    expect_txn(2, insn_of(2), ~insn_of(2), 1'b1, 1'b0, 3);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    drain(400, 1'b0);

    repeat (3) @(posedge clk);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, required completion");
    $fatal(1, "watchdog");
  end
endmodule
